// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one single-port 32-word data memory between two requesters:
// port 0 (core load/store unit) and port 1 (debug / DMA master).
// At most one beat is accepted per cycle. The granted port's address,
// write enable and write data drive the memory combinationally. The memory
// word read during the access (the old word, even on a write) comes back on
// the issuing port one cycle later. A lock gives one port exclusive
// back-to-back access for read-modify-write, bounded to LOCK_MAX cycles.
//
// Parameters
//   RR_ENABLE  1 = round-robin on contention, 0 = port 0 always wins
//   LOCK_MAX   maximum consecutive locked cycles (1..15)
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   reqN_valid/write/lock/addr/wdata request from port N
//   reqN_ready                       beat accepted this cycle (combinational)
//   rspN_valid/rdata                 response for port N's beat of last cycle
//   mem_addr/mem_write/mem_wdata     to memory
//   mem_rdata                        from memory, one cycle after the access
module dmem_arbiter #(
    parameter int RR_ENABLE = 1,
    parameter int LOCK_MAX  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_write,
    input  logic        req0_lock,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_write,
    input  logic        req1_lock,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_rdata,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] LOCK_LIM = 4'(LOCK_MAX);

    logic       locked;
    logic       lock_owner;
    logic [3:0] lock_cnt;
    logic       last_grant;
    logic       rsp_vld_p1;
    logic       rsp_port_p1;

    logic       gnt0;
    logic       gnt1;
    logic       accept;
    logic       acc_lock;

    // Grant is only ever given to a valid port, so ready doubles as grant.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (locked) begin
            gnt0 = req0_valid & ~lock_owner;
            gnt1 = req1_valid &  lock_owner;
        end else if (req0_valid && req1_valid) begin
            if ((RR_ENABLE != 0) && (last_grant == 1'b0)) begin
                gnt1 = 1'b1;
            end else begin
                gnt0 = 1'b1;
            end
        end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign accept     = gnt0 | gnt1;
    assign acc_lock   = gnt1 ? req1_lock : req0_lock;

    // Stage p0: memory request, zeroed on idle cycles.
    always_comb begin
        mem_addr  = '0;
        mem_write = 1'b0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_addr  = req0_addr;
            mem_write = req0_write;
            mem_wdata = req0_wdata;
        end else if (gnt1) begin
            mem_addr  = req1_addr;
            mem_write = req1_write;
            mem_wdata = req1_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant  <= 1'b1;
            locked      <= 1'b0;
            lock_owner  <= 1'b0;
            lock_cnt    <= '0;
            rsp_vld_p1  <= 1'b0;
            rsp_port_p1 <= 1'b0;
        end else begin
            if (accept) begin
                last_grant <= gnt1;
            end
            rsp_vld_p1  <= accept;
            rsp_port_p1 <= gnt1;
            // While locked only the owner can be accepted. Hitting the limit
            // releases even if the owner asks to keep the lock this cycle.
            if (locked) begin
                if ((lock_cnt == LOCK_LIM) || (accept && !acc_lock)) begin
                    locked   <= 1'b0;
                    lock_cnt <= '0;
                end else begin
                    lock_cnt <= lock_cnt + 4'd1;
                end
            end else if (accept && acc_lock) begin
                locked     <= 1'b1;
                lock_owner <= gnt1;
                lock_cnt   <= 4'd1;
            end
        end
    end

    // Stage p1: memory data returns to the port that issued the beat.
    assign rsp0_valid = rsp_vld_p1 & ~rsp_port_p1;
    assign rsp1_valid = rsp_vld_p1 &  rsp_port_p1;
    assign rsp0_rdata = rsp0_valid ? mem_rdata : '0;
    assign rsp1_rdata = rsp1_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Drives two arbiter instances with identical requests: instance 0 in
// round-robin mode, instance 1 in fixed-priority mode, each with its own
// 32-word memory. A transaction-level model (grant rules, shadow memory,
// lock expiry by cycle number) predicts every output each cycle.
module tb_dmem_arbiter;

    localparam int LOCK_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_write = 1'b0, req1_write = 1'b0;
    logic        req0_lock = 1'b0, req1_lock = 1'b0;
    logic [31:0] req0_addr = '0, req1_addr = '0;
    logic [31:0] req0_wdata = '0, req1_wdata = '0;

    logic        rdy0 [2];
    logic        rdy1 [2];
    logic        rv0  [2];
    logic        rv1  [2];
    logic [31:0] rd0  [2];
    logic [31:0] rd1  [2];
    logic [31:0] ma   [2];
    logic        mw   [2];
    logic [31:0] md   [2];
    logic [31:0] mrd  [2];
    logic [31:0] pmem [2][32];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // model state
    int          m_last    [2];
    bit          m_lock_on [2];
    int          m_owner   [2];
    int          m_lock_end[2];
    bit          m_pend    [2];
    int          m_pport   [2];
    logic [31:0] m_pdata   [2];
    logic [31:0] mmem      [2][32];
    logic        obs_rdy0  [2];
    logic        obs_rdy1  [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dmem_arbiter #(
            .RR_ENABLE(g == 0 ? 1 : 0),
            .LOCK_MAX (LOCK_MAX)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req0_valid(req0_valid),
            .req0_ready(rdy0[g]),
            .req0_write(req0_write),
            .req0_lock (req0_lock),
            .req0_addr (req0_addr),
            .req0_wdata(req0_wdata),
            .req1_valid(req1_valid),
            .req1_ready(rdy1[g]),
            .req1_write(req1_write),
            .req1_lock (req1_lock),
            .req1_addr (req1_addr),
            .req1_wdata(req1_wdata),
            .rsp0_valid(rv0[g]),
            .rsp0_rdata(rd0[g]),
            .rsp1_valid(rv1[g]),
            .rsp1_rdata(rd1[g]),
            .mem_addr  (ma[g]),
            .mem_write (mw[g]),
            .mem_wdata (md[g]),
            .mem_rdata (mrd[g])
        );
    end

    function automatic logic [31:0] init_word(input int i);
        if (i == 3) return 32'hDEADBEEF;
        if (i == 7) return 32'hA5A5A5A5;
        return 32'h5A000000 | (32'(i) * 32'h00010203);
    endfunction

    // Synchronous single-port memories, old word returned one cycle later.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!rst_n) begin
                for (int i = 0; i < 32; i++) pmem[g][i] <= init_word(i);
                mrd[g] <= '0;
            end else begin
                if (mw[g]) pmem[g][ma[g][4:0]] <= md[g];
                mrd[g] <= pmem[g][ma[g][4:0]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < 2; g++) begin
            m_last[g]    = 1;
            m_lock_on[g] = 1'b0;
            m_owner[g]   = 0;
            m_lock_end[g] = 0;
            m_pend[g]    = 1'b0;
            m_pport[g]   = 0;
            m_pdata[g]   = '0;
            for (int i = 0; i < 32; i++) mmem[g][i] = init_word(i);
        end
    endtask

    // Reset held across one rising edge; all outputs must read zero.
    task automatic do_reset();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_write = 1'b0; req1_write = 1'b0;
        req0_lock  = 1'b0; req1_lock  = 1'b0;
        req0_addr  = '0;   req1_addr  = '0;
        req0_wdata = '0;   req1_wdata = '0;
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            chk1($sformatf("rst_async_rsp0_valid[%0d]", g), rv0[g], 1'b0);
            chk1($sformatf("rst_async_rsp1_valid[%0d]", g), rv1[g], 1'b0);
        end
        @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk1($sformatf("rst_ready0[%0d]", g), rdy0[g], 1'b0);
            chk1($sformatf("rst_ready1[%0d]", g), rdy1[g], 1'b0);
            chk1($sformatf("rst_rsp0_valid[%0d]", g), rv0[g], 1'b0);
            chk1($sformatf("rst_rsp1_valid[%0d]", g), rv1[g], 1'b0);
            chk($sformatf("rst_rsp0_rdata[%0d]", g), rd0[g], 32'h0);
            chk($sformatf("rst_rsp1_rdata[%0d]", g), rd1[g], 32'h0);
            chk1($sformatf("rst_mem_write[%0d]", g), mw[g], 1'b0);
            chk($sformatf("rst_mem_addr[%0d]", g), ma[g], 32'h0);
            chk($sformatf("rst_mem_wdata[%0d]", g), md[g], 32'h0);
        end
        model_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock cycle: apply requests, check both instances against the
    // model at the falling edge, advance the model, return just after the
    // next rising edge.
    task automatic cycle(input bit v0, input bit v1, input bit w0, input bit w1,
                         input bit l0, input bit l1,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        int          gnt;
        bit          wr, lk;
        logic [31:0] a, d;
        req0_valid = v0; req1_valid = v1;
        req0_write = w0; req1_write = w1;
        req0_lock  = l0; req1_lock  = l1;
        req0_addr  = a0; req1_addr  = a1;
        req0_wdata = d0; req1_wdata = d1;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            gnt = -1;
            if (m_lock_on[g]) begin
                if (m_owner[g] == 0 && v0) gnt = 0;
                else if (m_owner[g] == 1 && v1) gnt = 1;
            end else if (v0 && v1) begin
                gnt = (g == 0) ? 1 - m_last[g] : 0;
            end else if (v0) begin
                gnt = 0;
            end else if (v1) begin
                gnt = 1;
            end
            wr = (gnt == 1) ? w1 : w0;
            lk = (gnt == 1) ? l1 : l0;
            a  = (gnt == 1) ? a1 : a0;
            d  = (gnt == 1) ? d1 : d0;
            chk1($sformatf("c%0d_ready0[%0d]", cyc, g), rdy0[g], gnt == 0);
            chk1($sformatf("c%0d_ready1[%0d]", cyc, g), rdy1[g], gnt == 1);
            chk1($sformatf("c%0d_mem_write[%0d]", cyc, g), mw[g], (gnt >= 0) && wr);
            chk($sformatf("c%0d_mem_addr[%0d]", cyc, g), ma[g], (gnt >= 0) ? a : 32'h0);
            chk($sformatf("c%0d_mem_wdata[%0d]", cyc, g), md[g], (gnt >= 0) ? d : 32'h0);
            chk1($sformatf("c%0d_rsp0_valid[%0d]", cyc, g), rv0[g], m_pend[g] && m_pport[g] == 0);
            chk1($sformatf("c%0d_rsp1_valid[%0d]", cyc, g), rv1[g], m_pend[g] && m_pport[g] == 1);
            chk($sformatf("c%0d_rsp0_rdata[%0d]", cyc, g), rd0[g],
                (m_pend[g] && m_pport[g] == 0) ? m_pdata[g] : 32'h0);
            chk($sformatf("c%0d_rsp1_rdata[%0d]", cyc, g), rd1[g],
                (m_pend[g] && m_pport[g] == 1) ? m_pdata[g] : 32'h0);
            obs_rdy0[g] = rdy0[g];
            obs_rdy1[g] = rdy1[g];
            m_pend[g] = (gnt >= 0);
            if (gnt >= 0) begin
                m_pport[g] = gnt;
                m_pdata[g] = mmem[g][a[4:0]];
                if (wr) mmem[g][a[4:0]] = d;
                m_last[g] = gnt;
            end
            if (m_lock_on[g]) begin
                if (cyc == m_lock_end[g] || (gnt >= 0 && !lk)) m_lock_on[g] = 1'b0;
            end else if (gnt >= 0 && lk) begin
                m_lock_on[g]  = 1'b1;
                m_owner[g]    = gnt;
                m_lock_end[g] = cyc + LOCK_MAX;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        model_reset();
        do_reset();

        // single read of word 3
        cycle(1, 0, 0, 0, 0, 0, 32'd3, 32'd0, 32'h0, 32'h0);
        chk1("read_ready0", obs_rdy0[0], 1'b1);
        chk1("read_rsp0_valid", rv0[0], 1'b1);
        chk("read_rsp0_rdata", rd0[0], 32'hDEADBEEF);
        chk1("read_rsp1_valid", rv1[0], 1'b0);
        idle();

        // swap on word 7, then read back on the next beat
        cycle(0, 1, 0, 1, 0, 0, 32'd0, 32'd7, 32'h0, 32'h12345678);
        chk("swap_old_word", rd1[0], 32'hA5A5A5A5);
        cycle(1, 0, 0, 0, 0, 0, 32'd7, 32'd0, 32'h0, 32'h0);
        chk("swap_readback", rd0[0], 32'h12345678);
        idle();

        // contention after reset: RR grants 0,1,0,1; fixed grants 0 always
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, 0, 0, 0, 0, 32'(i), 32'(i + 8), 32'h0, 32'h0);
            chk1($sformatf("rr_ready0_%0d", i), obs_rdy0[0], (i % 2) == 0);
            chk1($sformatf("rr_ready1_%0d", i), obs_rdy1[0], (i % 2) == 1);
            chk1($sformatf("fp_ready0_%0d", i), obs_rdy0[1], 1'b1);
            chk1($sformatf("fp_ready1_%0d", i), obs_rdy1[1], 1'b0);
        end
        idle();

        // lock released by owner beat with lock=0
        do_reset();
        cycle(1, 1, 0, 0, 1, 0, 32'd1, 32'd2, 32'h0, 32'h0);
        chk1("lock_set_ready0", obs_rdy0[0], 1'b1);
        for (int i = 0; i < 2; i++) begin
            cycle(1, 1, 1, 0, 1, 0, 32'd1, 32'd2, 32'(i + 100), 32'h0);
            chk1($sformatf("lock_hold_ready1_%0d", i), obs_rdy1[0], 1'b0);
        end
        cycle(1, 1, 0, 0, 0, 0, 32'd1, 32'd2, 32'h0, 32'h0);
        chk1("lock_rel_ready0", obs_rdy0[0], 1'b1);
        chk1("lock_rel_ready1", obs_rdy1[0], 1'b0);
        cycle(0, 1, 0, 0, 0, 0, 32'd1, 32'd2, 32'h0, 32'h0);
        chk1("lock_after_ready1", obs_rdy1[0], 1'b1);
        idle();

        // lock timeout with owner idle: port 1 granted on cycle 5
        do_reset();
        cycle(1, 1, 0, 0, 1, 0, 32'd4, 32'd5, 32'h0, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            cycle(0, 1, 0, 0, 0, 0, 32'd4, 32'd5, 32'h0, 32'h0);
            chk1($sformatf("lock_to_ready1_%0d", k), obs_rdy1[0], k == 5);
        end
        idle();

        // reset the cycle after an accepted read
        cycle(1, 0, 0, 0, 0, 0, 32'd5, 32'd0, 32'h0, 32'h0);
        do_reset();
        cycle(1, 1, 0, 0, 0, 0, 32'd6, 32'd9, 32'h0, 32'h0);
        chk1("post_rst_rr_ready0", obs_rdy0[0], 1'b1);
        chk1("post_rst_fp_ready0", obs_rdy0[1], 1'b1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                  $urandom, $urandom, $urandom, $urandom);
        end
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
